// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle logic/arith/shift ops and
// iterative shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   p, p_step, prod;
    logic [WIDTH-1:0]     m, a_keep, mag_a, mag_b, q_fin, r_fin, fin_lo, fin_hi;
    logic [WIDTH-1:0]     alu_res, sum, diff;
    logic [WIDTH:0]       acc, r_sh, trial;
    logic [SHW-1:0]       sh;
    logic                 neg_lo, neg_hi, dz, sa, sb, is_md, accept, busy, last, alu_ov;

    assign in_ready = (state == IDLE) || (state == DONE);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state == MUL) || (state == DIV);
    assign last     = cnt == CW'(WIDTH - 1);
    assign is_md    = control[3] & control[2];
    assign sa       = !control[0] && a[WIDTH-1];
    assign sb       = !control[0] && b[WIDTH-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    assign sh       = b[SHW-1:0];
    assign sum      = a + b;
    assign diff     = a - b;

    // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign acc    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign r_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign trial  = r_sh - {1'b0, m};
    assign p_step = (state == DIV) ? {trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0], p[WIDTH-2:0], !trial[WIDTH]}
                                   : {acc, p[WIDTH-1:1]};
    assign prod   = neg_lo ? -p_step : p_step;
    assign q_fin  = dz ? '1 : neg_lo ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    assign r_fin  = dz ? a_keep : neg_hi ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
    assign fin_lo = (state == DIV) ? q_fin : prod[WIDTH-1:0];
    assign fin_hi = (state == DIV) ? r_fin : prod[2*WIDTH-1:WIDTH];

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (control)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0010: begin
                alu_res = sum;
                alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: alu_res = a ^ b;
            4'b0100: alu_res = ~(a | b);
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            4'b0110: begin
                alu_res = diff;
                alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: alu_res = a << sh;
            4'b1001: alu_res = a >> sh;
            4'b1010: alu_res = $signed(a) >>> sh;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (in_ready)
            state_next = accept && is_md ? (control[1] ? DIV : MUL) : IDLE;
        else if (flush)
            state_next = IDLE;
        else if (last)
            state_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            p           <= '0;
            m           <= '0;
            a_keep      <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && is_md) begin
                cnt    <= '0;
                m      <= control[1] ? mag_b : mag_a;
                p      <= {{WIDTH{1'b0}}, control[1] ? mag_a : mag_b};
                a_keep <= a;
                neg_lo <= sa ^ sb;
                neg_hi <= sa;
                dz     <= control[1] && (b == '0);
            end else if (accept) begin
                out_valid   <= 1'b1;
                result      <= alu_res;
                result_hi   <= '0;
                zero        <= alu_res == '0;
                overflow    <= alu_ov;
                div_by_zero <= 1'b0;
                illegal     <= control == 4'b1011;
            end else if (busy && !flush) begin
                p   <= p_step;
                cnt <= cnt + 1'b1;
                if (last) begin
                    out_valid   <= 1'b1;
                    result      <= fin_lo;
                    result_hi   <= fin_hi;
                    zero        <= fin_lo == '0;
                    overflow    <= 1'b0;
                    div_by_zero <= dz;
                    illegal     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  control = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] result, result_hi;
    logic        zero, overflow, div_by_zero, illegal;
    int          total = 0;
    int          bad = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .flush(flush), .out_valid(out_valid),
        .result(result), .result_hi(result_hi), .zero(zero), .overflow(overflow),
        .div_by_zero(div_by_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled on the falling edge
    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        control  = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc, output int low);
        cyc = 1;
        low = in_ready ? 0 : 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!in_ready) low++;
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({result, result_hi, zero, overflow, div_by_zero, illegal} !== 68'h0) begin
            bad++; $display("FAIL reset_outputs got=%h/%h/%b%b%b%b exp=0", result, result_hi, zero, overflow, div_by_zero, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        drive(4'b0010, 32'h7FFF_FFFF, 32'h1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h exp=80000000", result); end
        total++; if ({overflow, zero} !== 2'b10) begin bad++; $display("FAIL add_flags got=%b%b exp=10", overflow, zero); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", out_valid); end
        drive(4'b0110, 32'h8000_0000, 32'h1);
        total++; if ({result, overflow} !== {32'h7FFF_FFFF, 1'b1}) begin bad++; $display("FAIL sub_ovf got=%h/%b exp=7fffffff/1", result, overflow); end
        drive(4'b0110, 32'h5, 32'h7);
        total++; if ({result, overflow} !== {32'hFFFF_FFFE, 1'b0}) begin bad++; $display("FAIL sub got=%h/%b exp=fffffffe/0", result, overflow); end
        drive(4'b0100, 32'hFFFF_0000, 32'h0000_FFFF);
        total++; if ({result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL nor got=%h/%b exp=0/1", result, zero); end
        drive(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF);
        total++; if (result !== 32'hFF00_EDCB) begin bad++; $display("FAIL xor got=%h exp=ff00edcb", result); end
        drive(4'b1011, 32'h1234, 32'h5678);
        total++; if ({result, illegal, zero} !== {32'h0, 2'b11}) begin bad++; $display("FAIL illegal got=%h/%b%b exp=0/11", result, illegal, zero); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        control = 4'b0111; a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        total++; if ({out_valid, result} !== {1'b1, 32'h1}) begin bad++; $display("FAIL slt got=%b/%h exp=1/1", out_valid, result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        control = 4'b0101;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if ({out_valid, result, in_ready} !== {1'b1, 32'h0, 1'b1}) begin bad++; $display("FAIL sltu got=%b/%h/%b exp=1/0/1", out_valid, result, in_ready); end
    endtask

    task automatic test_shifts;
        drive(4'b1010, 32'h8000_0000, 32'd4);
        total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h exp=f8000000", result); end
        drive(4'b1001, 32'h8000_0000, 32'd4);
        total++; if (result !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h exp=08000000", result); end
        drive(4'b1000, 32'h1, 32'd31);
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL sll got=%h exp=80000000", result); end
        drive(4'b1000, 32'h3, 32'h0000_0121);
        total++; if (result !== 32'h6) begin bad++; $display("FAIL sll_mask got=%h exp=6", result); end
    endtask

    task automatic test_mult;
        int cyc, low;
        drive(4'b1100, -32'sd3, 32'd5);
        wait_result(cyc, low);
        total++; if (cyc !== 33) begin bad++; $display("FAIL mult_latency got=%0d exp=33", cyc); end
        total++; if (low !== 32) begin bad++; $display("FAIL mult_stall got=%0d exp=32", low); end
        total++; if ({result_hi, result} !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mult got=%h_%h exp=ffffffff_fffffff1", result_hi, result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mult_done_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mult_pulse got=%b exp=0", out_valid); end
        drive(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(cyc, low);
        total++; if ({result_hi, result} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu got=%h_%h exp=fffffffe_00000001", result_hi, result); end
    endtask

    task automatic test_div;
        int cyc, low;
        drive(4'b1110, -32'sd7, 32'd2);
        wait_result(cyc, low);
        total++; if (cyc !== 33) begin bad++; $display("FAIL div_latency got=%0d exp=33", cyc); end
        total++; if ({result, result_hi, div_by_zero} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
            bad++; $display("FAIL div got=%h/%h/%b exp=fffffffd/ffffffff/0", result, result_hi, div_by_zero);
        end
        drive(4'b1111, 32'd100, 32'd0);
        wait_result(cyc, low);
        total++; if (cyc !== 33) begin bad++; $display("FAIL divu0_latency got=%0d exp=33", cyc); end
        total++; if ({result, result_hi, div_by_zero} !== {32'hFFFF_FFFF, 32'd100, 1'b1}) begin
            bad++; $display("FAIL divu0 got=%h/%h/%b exp=ffffffff/00000064/1", result, result_hi, div_by_zero);
        end
        drive(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result(cyc, low);
        total++; if ({result, result_hi, overflow, div_by_zero} !== {32'h8000_0000, 32'h0, 2'b00}) begin
            bad++; $display("FAIL div_min got=%h/%h/%b%b exp=80000000/0/00", result, result_hi, overflow, div_by_zero);
        end
        drive(4'b1111, 32'd1000, 32'd7);
        wait_result(cyc, low);
        total++; if ({result, result_hi} !== {32'd142, 32'd6}) begin bad++; $display("FAIL divu got=%h/%h exp=8e/6", result, result_hi); end
    endtask

    task automatic test_flush;
        int seen;
        drive(4'b0010, 32'd1, 32'd1);
        drive(4'b1110, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL flush_idle got=%b%b exp=10", in_ready, out_valid); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
        total++; if (result !== 32'd2) begin bad++; $display("FAIL flush_hold got=%h exp=2", result); end
        control = 4'b0010; a = 32'd3; b = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        total++; if ({out_valid, result} !== {1'b0, 32'd2}) begin bad++; $display("FAIL flush_reject got=%b/%h exp=0/2", out_valid, result); end
    endtask

    task automatic test_reset_mid;
        drive(4'b1100, 32'd1234, 32'd5678);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL rstmid_hs got=%b%b exp=10", in_ready, out_valid); end
        total++; if ({result, result_hi, zero, overflow, div_by_zero, illegal} !== 68'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%h/%h exp=0", result, result_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0001, 32'hA0, 32'h0B);
        total++; if ({out_valid, result} !== {1'b1, 32'hAB}) begin bad++; $display("FAIL rstmid_recover got=%b/%h exp=1/ab", out_valid, result); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_shifts;
        test_mult;
        test_div;
        test_flush;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
